// File: rtl/shift_reg_pkg.sv
// Shared definitions for shift-register blocks: mode encodings and mode helpers.
package shift_reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROTL = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROTR = 3'd5;

    // True for any mode that moves bits one position (shift or rotate).
    function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

endpackage

// File: rtl/shift_word_counter.sv
// Counts shift/rotate operations modulo WIDTH and pulses word_done after each wrap.
module shift_word_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic at_last;
    assign at_last = (shift_cnt == LAST);

    // inc and clr are never both set by the top; clr still wins for safety.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= inc && !clr && at_last;
            if (clr) begin
                shift_cnt <= '0;
            end else if (inc) begin
                shift_cnt <= at_last ? '0 : shift_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift left/right, parallel load, rotate left/right.
module universal_shift_register
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        mode,
    input  logic              serial_in_lsb,
    input  logic              serial_in_msb,
    input  logic [WIDTH-1:0]  parallel_in,
    output logic [WIDTH-1:0]  parallel_out,
    output logic              serial_out_msb,
    output logic              serial_out_lsb,
    output logic [CNT_W-1:0]  shift_cnt,
    output logic              word_done
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            case (mode)
                MODE_SHL:  q <= {q[WIDTH-2:0], serial_in_lsb};
                MODE_SHR:  q <= {serial_in_msb, q[WIDTH-1:1]};
                MODE_LOAD: q <= parallel_in;
                MODE_ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROTR: q <= {q[0], q[WIDTH-1:1]};
                default:   q <= q;
            endcase
        end
    end

    // Serial outputs are plain taps of the register, so they stay flop-driven.
    assign parallel_out   = q;
    assign serial_out_msb = q[WIDTH-1];
    assign serial_out_lsb = q[0];

    shift_word_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .inc       (is_shift_mode(mode)),
        .clr       (mode == MODE_LOAD),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: directed scenarios plus a random soak.
module tb_universal_shift_register;
    import shift_reg_pkg::*;

    localparam int W     = 8;
    localparam int CW    = $clog2(W);
    localparam int EW    = W + CW + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    mode = MODE_HOLD;
    logic          serial_in_lsb = 1'b0;
    logic          serial_in_msb = 1'b0;
    logic [W-1:0]  parallel_in = '0;
    logic [W-1:0]  parallel_out;
    logic          serial_out_msb;
    logic          serial_out_lsb;
    logic [CW-1:0] shift_cnt;
    logic          word_done;

    int errors = 0;
    int checks = 0;

    logic [EW-1:0] exp_q[$];

    universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mode           (mode),
        .serial_in_lsb  (serial_in_lsb),
        .serial_in_msb  (serial_in_msb),
        .parallel_in    (parallel_in),
        .parallel_out   (parallel_out),
        .serial_out_msb (serial_out_msb),
        .serial_out_lsb (serial_out_lsb),
        .shift_cnt      (shift_cnt),
        .word_done      (word_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Register value as plain arithmetic; the counter is "total shifts since load" mod W.
    logic [W-1:0] m_q = '0;
    int           m_shifts = 0;
    logic         m_wd = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_q = '0;
            m_shifts = 0;
            m_wd = 1'b0;
        end else begin
            m_wd = 1'b0;
            case (mode)
                3'd1: m_q = (m_q << 1) | W'(serial_in_lsb);
                3'd2: m_q = (m_q >> 1) | (W'(serial_in_msb) << (W - 1));
                3'd3: m_q = parallel_in;
                3'd4: m_q = (m_q << 1) | (m_q >> (W - 1));
                3'd5: m_q = (m_q >> 1) | (m_q << (W - 1));
                default: ;
            endcase
            if (mode == 3'd3) m_shifts = 0;
            if (mode inside {3'd1, 3'd2, 3'd4, 3'd5}) begin
                m_shifts++;
                m_wd = (m_shifts % W) == 0;
            end
        end
        exp_q.push_back({m_wd, CW'(m_shifts % W), m_q});
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("model_pout", 64'(parallel_out), 64'(e[W-1:0]));
            chk("model_cnt",  64'(shift_cnt),    64'(e[W+CW-1:W]));
            chk("model_wd",   64'(word_done),    64'(e[EW-1]));
            chk("model_smsb", 64'(serial_out_msb), 64'(e[W-1]));
            chk("model_slsb", 64'(serial_out_lsb), 64'(e[0]));
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge: applies inputs, returns at the next negedge with the result visible.
    task automatic cyc(input logic rn, input logic [2:0] md, input logic sl, input logic sm,
                       input logic [W-1:0] pi);
        reset_n       = rn;
        mode          = md;
        serial_in_lsb = sl;
        serial_in_msb = sm;
        parallel_in   = pi;
        @(negedge clk);
    endtask

    task automatic op(input logic [2:0] md, input logic [W-1:0] pi = '0,
                      input logic sl = 1'b0, input logic sm = 1'b0);
        cyc(1'b1, md, sl, sm, pi);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [W-1:0] frozen;
        @(negedge clk);

        // Reset with LOAD of all ones pending
        cyc(1'b0, MODE_LOAD, 1'b0, 1'b0, 8'hFF);
        cyc(1'b0, MODE_LOAD, 1'b0, 1'b0, 8'hFF);
        chk("rst_pout", 64'(parallel_out), 64'h00);
        chk("rst_cnt",  64'(shift_cnt), 64'd0);
        chk("rst_wd",   64'(word_done), 64'd0);

        // Load then SHL
        op(MODE_LOAD, 8'hA5);
        chk("load_a5", 64'(parallel_out), 64'hA5);
        op(MODE_SHL, '0, 1'b1);
        chk("shl_pout", 64'(parallel_out), 64'h4B);
        chk("shl_smsb", 64'(serial_out_msb), 64'd0);
        chk("shl_cnt",  64'(shift_cnt), 64'd1);

        // SHR twice
        op(MODE_LOAD, 8'h81);
        op(MODE_SHR, '0, 1'b0, 1'b0);
        chk("shr1_pout", 64'(parallel_out), 64'h40);
        chk("shr1_slsb", 64'(serial_out_lsb), 64'd0);
        op(MODE_SHR, '0, 1'b0, 1'b0);
        chk("shr2_pout", 64'(parallel_out), 64'h20);
        chk("shr2_slsb", 64'(serial_out_lsb), 64'd0);

        // Full rotation: word_done only after the 8th ROTL
        op(MODE_LOAD, 8'h96);
        for (int i = 1; i <= W; i++) begin
            op(MODE_ROTL);
            if (i < W) chk("rotl_wd_low", 64'(word_done), 64'd0);
        end
        chk("rotl_pout", 64'(parallel_out), 64'h96);
        chk("rotl_wd",   64'(word_done), 64'd1);
        chk("rotl_cnt",  64'(shift_cnt), 64'd0);
        // LOAD while word_done is high
        op(MODE_LOAD, 8'h11);
        chk("ldwd_wd",  64'(word_done), 64'd0);
        chk("ldwd_cnt", 64'(shift_cnt), 64'd0);

        // 7 SHL then LOAD: no wrap, no pulse
        for (int i = 0; i < 7; i++) op(MODE_SHL, '0, 1'b1);
        chk("shl7_cnt", 64'(shift_cnt), 64'd7);
        op(MODE_LOAD, 8'h3C);
        chk("ld3c_pout", 64'(parallel_out), 64'h3C);
        chk("ld3c_cnt",  64'(shift_cnt), 64'd0);
        chk("ld3c_wd",   64'(word_done), 64'd0);
        op(MODE_HOLD);
        chk("ld3c_wd2",  64'(word_done), 64'd0);

        // 4 ROTR, invalid mode freezes, reset abandons the word
        op(MODE_LOAD, 8'h5A);
        for (int i = 0; i < 4; i++) op(MODE_ROTR);
        chk("rotr4_pout", 64'(parallel_out), 64'hA5);
        chk("rotr4_cnt",  64'(shift_cnt), 64'd4);
        frozen = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            op(3'd6);
            chk("mode6_pout", 64'(parallel_out), 64'(frozen));
            chk("mode6_cnt",  64'(shift_cnt), 64'd4);
            chk("mode6_wd",   64'(word_done), 64'd0);
        end
        cyc(1'b0, MODE_ROTR, 1'b1, 1'b1, 8'hFF);
        chk("rst2_pout", 64'(parallel_out), 64'h00);
        chk("rst2_cnt",  64'(shift_cnt), 64'd0);
        chk("rst2_wd",   64'(word_done), 64'd0);
        chk("rst2_smsb", 64'(serial_out_msb), 64'd0);
        chk("rst2_slsb", 64'(serial_out_lsb), 64'd0);

        // Random soak, shift-heavy so wraps occur often
        for (int i = 0; i < 2500; i++) begin
            logic [2:0] md;
            md = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'($urandom_range(4, 5) - 3 * $urandom_range(0, 1));
            cyc(($urandom_range(0, 60) != 0), md, 1'($urandom), 1'($urandom), W'($urandom));
        end
        op(MODE_HOLD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal range is 2..64.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH), giving the shift-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port mode, input, 3 bits: the operation select, per REQ-011.
REQ-006 The block SHALL have port serial_in_lsb, input, 1 bit: the bit entering at bit 0 on a shift-left.
REQ-007 The block SHALL have port serial_in_msb, input, 1 bit: the bit entering at bit WIDTH-1 on a shift-right.
REQ-008 The block SHALL have port parallel_in, input, WIDTH bits: the load data.
REQ-009 The block SHALL have the following output ports:
- parallel_out, WIDTH bits: the current register contents.
- serial_out_msb, 1 bit: equals parallel_out[WIDTH-1].
- serial_out_lsb, 1 bit: equals parallel_out[0].
- shift_cnt, CNT_W bits: the number of shift/rotate operations since the last load, modulo WIDTH.
- word_done, 1 bit: a registered one-cycle pulse, per REQ-015.
REQ-010 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Function
REQ-011 The mode encoding SHALL be:
- 0 HOLD
- 1 SHL: q <= {q[WIDTH-2:0], serial_in_lsb}
- 2 SHR: q <= {serial_in_msb, q[WIDTH-1:1]}
- 3 LOAD: q <= parallel_in
- 4 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}
- 5 ROTR: q <= {q[0], q[WIDTH-1:1]}
- 6 and 7: treated as HOLD
REQ-012 Every operation SHALL take effect in the cycle after the edge that samples it (latency 1), and parallel_out SHALL reflect it immediately after that edge.
REQ-013 Exactly one operation SHALL occur per cycle; mode fully arbitrates, and no simultaneous-operation case exists.
REQ-014 The shift counter SHALL behave as follows:
- SHL/SHR/ROTL/ROTR increment shift_cnt.
- When shift_cnt = WIDTH-1, the next shift/rotate wraps it to 0.
- LOAD clears it to 0.
- HOLD and invalid modes leave it unchanged.
REQ-015 word_done SHALL be 1 in the cycle following a shift/rotate that wrapped shift_cnt from WIDTH-1 to 0, and 0 otherwise; it SHALL never stay high for two consecutive cycles unless a wrap occurs on each of those edges.
REQ-016 A LOAD issued in the same cycle that word_done is high SHALL clear shift_cnt and not extend word_done.
REQ-017 serial_out_msb after a SHL SHALL be the bit formerly at position WIDTH-2, so no bit is lost between parallel_out and the serial outputs.
REQ-018 After WIDTH consecutive ROTL or ROTR operations from any state, parallel_out SHALL equal its starting value and word_done SHALL pulse once, provided shift_cnt started at 0.

Reset
REQ-019 When reset_n = 0 at a rising clk edge, the block SHALL set parallel_out, shift_cnt and word_done to 0, and therefore serial_out_msb and serial_out_lsb to 0.
REQ-020 Reset SHALL take priority over every mode.
REQ-021 Reset asserted mid-word SHALL abandon the count without a word_done pulse.
REQ-022 On the first edge with reset_n = 1, the block SHALL execute the sampled mode normally.
REQ-023 The block SHALL have no asynchronous reset path.

Structure
REQ-024 The mode encodings (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROTL, MODE_ROTR) SHALL be defined as named constants in the shared package shift_reg_pkg, for reuse by future shift-register blocks and benches.
REQ-025 The counter and word_done logic SHALL be a sub-module, shift_word_counter, with parameters WIDTH and CNT_W and inputs clk, reset_n, inc and clr.
REQ-026 The data path SHALL remain in the top module as a single registered case on mode.

Verification
REQ-027 The bench SHALL cover the following directed scenarios, each with WIDTH=8:
- Reset: reset_n=0 for 2 cycles with mode=LOAD and parallel_in=8'hFF -> parallel_out=8'h00, shift_cnt=0, word_done=0.
- Load then SHL: LOAD 8'hA5, then SHL with serial_in_lsb=1 -> parallel_out=8'h4B, serial_out_msb=0, shift_cnt=1.
- SHR: LOAD 8'h81, then SHR with serial_in_msb=0 twice -> 8'h40 then 8'h20; serial_out_lsb=0 then 0.
- Rotation: LOAD 8'h96, then 8 cycles of ROTL -> parallel_out=8'h96 after cycle 8; word_done high exactly one cycle, the cycle after the 8th ROTL; shift_cnt=0.
- Boundaries: 7 SHL, then LOAD 8'h3C -> shift_cnt=0 and no word_done; separately, 4 ROTR, then mode=6 for 3 cycles, then reset_n=0 -> contents frozen for the 3 cycles, then all outputs 0 with no word_done.
- Randomised mixed modes against a reference model: at least 2000 cycles with no mismatch on any output.
